// File: rtl/alu_serial_exec.sv
// ---------------------------------------------------------------------------
// alu_serial_exec
//
// Byte-serial ALU. A request is accepted in IDLE. Its operands are then
// processed one byte per clock, least significant byte first. The final
// result is presented on a registered valid/ready output port.
//
// Handshake rules (apply to both ports):
//   A transfer happens on a rising edge where valid && ready are both 1.
//   A producer may not drop valid, or change the payload, before the
//   transfer. A consumer may change ready freely.
//   in_ready is a pure function of state. It has no path from in_valid.
//
// Parameters:
//   WIDTH      operand/result width. Must be a multiple of 8 in 8..64.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   request present
//   in_ready   block is idle and can take a request
//   ALUControl opcode: 010 add, 110 sub, 000 and, 001 or, 100 xor, 111 slt,
//              any other code executes as add
//   SrcA/SrcB  operands, captured on acceptance
//   out_valid  ALUResult/Zero hold a completed result
//   out_ready  consumer takes the result
//   ALUResult  registered result
//   Zero       registered, 1 when ALUResult == 0
//   state_dbg  current FSM state (0 IDLE, 1 RUN, 2 DONE)
// ---------------------------------------------------------------------------
module alu_serial_exec #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       ALUControl,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Zero,
    output logic [1:0]       state_dbg
);

    localparam int NB = WIDTH / 8;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]    cnt;
    logic             carry;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] a_q, b_q, acc;

    logic             last_byte;
    logic             op_is_sub;
    logic             new_is_sub;
    logic [7:0]       a_byte, b_byte, b_eff, res_byte;
    logic [8:0]       sum;
    logic [WIDTH-1:0] acc_next, final_res;
    logic             slt_bit;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign state_dbg = state;

    assign last_byte  = (cnt == CW'(NB - 1));
    assign op_is_sub  = (op_q == OP_SUB) || (op_q == OP_SLT);
    assign new_is_sub = (ALUControl == OP_SUB) || (ALUControl == OP_SLT);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)  state_next = RUN;
            RUN:     if (last_byte) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Byte slice datapath
    // ------------------------------------------------------------------
    always_comb begin
        a_byte = '0;
        b_byte = '0;
        // Loop over constant slices so the select stays a plain mux.
        for (int k = 0; k < NB; k++) begin
            if (int'(cnt) == k) begin
                a_byte = a_q[8*k +: 8];
                b_byte = b_q[8*k +: 8];
            end
        end

        // sub/slt compute A + ~B + 1. The +1 enters as the initial carry.
        b_eff = op_is_sub ? ~b_byte : b_byte;
        sum   = {1'b0, a_byte} + {1'b0, b_eff} + {8'd0, carry};

        case (op_q)
            OP_AND:  res_byte = a_byte & b_byte;
            OP_OR:   res_byte = a_byte | b_byte;
            OP_XOR:  res_byte = a_byte ^ b_byte;
            default: res_byte = sum[7:0];
        endcase

        acc_next = acc;
        for (int k = 0; k < NB; k++) begin
            if (int'(cnt) == k) acc_next[8*k +: 8] = res_byte;
        end

        // Only meaningful on the last byte. sum[7] is the difference MSB.
        // Overflow occurs when the operand signs differ and the result sign
        // differs from A.
        slt_bit = sum[7] ^ ((a_q[WIDTH-1] ^ b_q[WIDTH-1]) &
                            (a_q[WIDTH-1] ^ sum[7]));

        final_res = (op_q == OP_SLT) ? {{(WIDTH-1){1'b0}}, slt_bit} : acc_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            carry     <= 1'b0;
            op_q      <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc       <= '0;
            ALUResult <= '0;
            Zero      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        op_q  <= ALUControl;
                        a_q   <= SrcA;
                        b_q   <= SrcB;
                        cnt   <= '0;
                        carry <= new_is_sub;
                        acc   <= '0;
                    end
                end
                RUN: begin
                    cnt   <= cnt + CW'(1);
                    carry <= sum[8];
                    acc   <= acc_next;
                    // Outputs change only when the result is complete.
                    // They then hold through DONE and after consumption.
                    if (last_byte) begin
                        ALUResult <= final_res;
                        Zero      <= (final_res == '0);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_exec.sv
module tb_alu_serial_exec;

  localparam int W = 32;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   ALUControl;
  logic [W-1:0] SrcA, SrcB;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] ALUResult;
  logic         Zero;
  logic [1:0]   state_dbg;

  alu_serial_exec #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ALUControl (ALUControl),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ALUResult  (ALUResult),
    .Zero       (Zero),
    .state_dbg  (state_dbg)
  );

  int n_vec = 0;
  int n_err = 0;

  // scoreboard entries are {zero, result}
  logic [W:0] exp_q[$];

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         z;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // behavioural reference: whole-word operation
  function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b);
    case (op)
      3'b110:  return a - b;
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b100:  return a ^ b;
      3'b111:  return ($signed(a) < $signed(b)) ? W'(1) : W'(0);
      default: return a + b;
    endcase
  endfunction

  // driver: wait for in_ready, present one request, returns #1 after the accept edge
  task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] res, input logic z, input bit push);
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) chk("in_ready_wait", {63'd0, in_ready}, 64'd1);
    in_valid   = 1'b1;
    ALUControl = op;
    SrcA       = a;
    SrcB       = b;
    if (push) exp_q.push_back({z, res});
    @(posedge clk);
    #1;
    // scramble inputs while the op is in flight
    in_valid   = 1'b0;
    SrcA       = $urandom;
    SrcB       = $urandom;
    ALUControl = 3'($urandom_range(0, 7));
  endtask

  // monitor: wait for out_valid, check latency and pop/compare
  task automatic wait_result();
    int lat;
    logic [W:0] e;
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (!out_valid && lat > 0) begin
        ALUControl = 3'($urandom_range(0, 7));
        SrcA = $urandom;
      end
    end
    chk("latency", 64'(lat), 64'd4);
    chk("in_ready_busy", {63'd0, in_ready}, 64'd0);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("result", 64'(ALUResult), 64'(e[W-1:0]));
      chk("zero", {63'd0, Zero}, {63'd0, e[W]});
    end else begin
      chk("scoreboard_empty", 64'(exp_q.size()), 64'd1);
    end
  endtask

  task automatic run_vec(input vec_t v);
    issue(v.op, v.a, v.b, v.res, v.z, 1'b1);
    wait_result();
    @(posedge clk);
    #1;
    chk("out_valid_fall", {63'd0, out_valid}, 64'd0);
    chk("in_ready_after", {63'd0, in_ready}, 64'd1);
  endtask

  initial begin
    logic [W-1:0] r;
    vec_t v;

    // spec vectors
    vecs[0]  = '{3'b010, 32'h0000_00FF, 32'h0000_0001, 32'h0000_0100, 1'b0};
    vecs[1]  = '{3'b110, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b1};
    vecs[2]  = '{3'b110, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0};
    vecs[3]  = '{3'b111, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 1'b0};
    vecs[4]  = '{3'b111, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    vecs[5]  = '{3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0};
    vecs[6]  = '{3'b001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 1'b0};
    vecs[7]  = '{3'b100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1'b0};
    vecs[8]  = '{3'b011, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hEFF1_EFF0, 1'b0};
    vecs[9]  = '{3'b111, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0};
    vecs[10] = '{3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
    vecs[11] = '{3'b111, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b1};
    // random vectors, expectation from the reference model
    for (int i = 12; i < 20; i++) begin
      v.op  = 3'($urandom_range(0, 7));
      v.a   = $urandom;
      v.b   = (i == 13) ? v.a : $urandom;
      v.res = model(v.op, v.a, v.b);
      v.z   = (v.res == '0);
      vecs[i] = v;
    end

    // reset, with in_valid high to prove it is ignored
    reset      = 1'b1;
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    ALUControl = 3'b010;
    SrcA       = 32'h1;
    SrcB       = 32'h1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_result", 64'(ALUResult), 64'd0);
    chk("rst_zero", {63'd0, Zero}, 64'd0);
    chk("rst_state", 64'(state_dbg), 64'd0);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;

    // table-driven vectors
    for (int i = 0; i < 20; i++) run_vec(vecs[i]);

    // backpressure: 10 cycles in DONE with inputs toggling
    out_ready = 1'b0;
    issue(3'b010, 32'h1122_3344, 32'h0101_0101, 32'h1223_3445, 1'b0, 1'b1);
    wait_result();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid   = 1'($urandom_range(0, 1));
      SrcA       = $urandom;
      SrcB       = $urandom;
      ALUControl = 3'($urandom_range(0, 7));
      @(posedge clk);
      #1;
      chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
      chk("bp_result", 64'(ALUResult), 64'h1223_3445);
      chk("bp_zero", {63'd0, Zero}, 64'd0);
      chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
    end
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("hs_out_valid", {63'd0, out_valid}, 64'd0);
    chk("hs_in_ready", {63'd0, in_ready}, 64'd1);
    chk("hs_result_hold", 64'(ALUResult), 64'h1223_3445);
    @(posedge clk);
    #1;
    chk("hs_no_accept", {63'd0, in_ready}, 64'd1);

    // reset two cycles after accept aborts the op
    issue(3'b010, 32'h5, 32'h6, 32'hB, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
    chk("abort_result", 64'(ALUResult), 64'd0);
    chk("abort_zero", {63'd0, Zero}, 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("abort_no_valid", {63'd0, out_valid}, 64'd0);
    end
    v = '{3'b010, 32'h0000_FFFF, 32'h0000_0001, 32'h0001_0000, 1'b0};
    run_vec(v);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
